sm83_bus_responder: RTL and testbench
=====================================

// Module: sm83_bus_responder
// PURPOSE
//  Memory-side responder for the SM83 core's data bus: the other end of the accesses the control sequencer issues.
//  - Decodes every CPU read/write.
//  - Serves HRAM, IF, IE and the boot-ROM-disable latch internally.
//  - Forwards all other mapped addresses to external memory over a req/ack handshake.
//  - Returns read data with a ready pulse.
// PARAMETERS
//  EXT_TIMEOUT  255  max cycles waiting for ext_ack before abort (1..255)
//  BOOT_SIZE    256  boot ROM overlay size in bytes, mapped at 0x0000 (power of 2, <=256)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  cpu_addr     in   16  access address, sampled with cpu_rd/cpu_wr
//  cpu_rd       in   1   read request, 1-cycle pulse
//  cpu_wr       in   1   write request, 1-cycle pulse
//  cpu_wdata    in   8   write data, sampled with cpu_wr
//  cpu_rdata    out  8   read data, valid only while cpu_ready=1
//  cpu_ready    out  1   1-cycle completion pulse, for reads and writes
//  ext_req      out  1   external access request, held until ext_ack or timeout
//  ext_we       out  1   external write enable, stable while ext_req
//  ext_addr     out  16  external address, stable while ext_req
//  ext_wdata    out  8   external write data, stable while ext_req
//  ext_ack      in   1   external completion; ext_rdata valid in the same cycle
//  ext_rdata    in   8   external read data
//  boot_addr    out  8   boot ROM address (synchronous ROM, 1-cycle read)
//  boot_rdata   in   8   boot ROM data
//  irq_set      in   5   interrupt sources, per-bit set pulses into IF
//  irq_clr      in   5   dispatch clear of IF bits from the core
//  irq_pending  out  1   |(IE[4:0] & IF[4:0]), combinational from registers
//  bus_err      out  1   1-cycle pulse on external timeout
// BEHAVIOUR
//  Reset values
//   - Outputs: cpu_ready=0, cpu_rdata=0xFF, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, boot_addr=0, bus_err=0.
//   - Registers: IF=0, IE=0, boot_en=1, FSM=IDLE. HRAM is not reset.
//  Address map
//   - FF80-FFFE: HRAM (127 B).
//   - FFFF: IE (8 b).
//   - FF0F: IF; reads {3'b111, IF}.
//   - FF50: boot latch; any nonzero write clears boot_en (one-way; only reset sets it); reads {7'h7F, ~boot_en}.
//   - FEA0-FEFF: unmapped; reads 0xFF, writes dropped.
//   - Everything else: external, except the boot overlay.
//  FSM states: IDLE, INT_RESP, EXT_WAIT, EXT_RESP.
//   - IDLE + request to an internal address -> INT_RESP. Write commits on the request edge. cpu_ready=1 next cycle (latency 1).
//   - IDLE + request to an external address -> EXT_WAIT. ext_req is asserted the next cycle; ext_addr/ext_we/ext_wdata are captured then.
//   - EXT_WAIT + ext_ack -> EXT_RESP. ext_rdata is latched; ext_req drops the cycle after ack. cpu_ready is driven the cycle after ack.
//   - EXT_WAIT, timeout counter reaches EXT_TIMEOUT with no ack -> EXT_RESP. ext_req drops. cpu_rdata=0xFF; bus_err pulses with cpu_ready.
//   - INT_RESP / EXT_RESP -> IDLE unconditionally.
//  Request rules
//   - cpu_rd and cpu_wr together: treated as write; rdata=0xFF.
//   - A request outside IDLE is a protocol violation; it is ignored with no ready.
//   - ext_ack outside EXT_WAIT is ignored.
//  IF update, per bit: next = (IF & ~irq_clr) | irq_set.
//   - A same-cycle CPU write to FF0F replaces the IF term; set still wins.
//  Timeout counter: 8 b, cleared on EXT_WAIT entry; increments each EXT_WAIT cycle without ack. An ack on the same cycle as expiry counts as ack.
//  Reset mid-access: FSM returns to IDLE and ext_req drops asynchronously. No ready is issued; the pending write is lost.
// CONFIGURATION
//  SM83_BOOT_OVERLAY_EN
//   Defined:
//    - While boot_en=1, reads at addr < BOOT_SIZE go to boot ROM, not external.
//    - boot_addr=cpu_addr[7:0] is registered on the request edge; boot_rdata is returned with ready at latency 2 (INT_RESP extended one cycle).
//    - Writes in the overlay window still go external.
//   Undefined:
//    - No overlay; boot_addr is tied to 0 and boot_rdata is ignored.
//    - The FF50 latch still exists and reads as described.
// TESTING
//  1. Write 0x5A to FF80, then read FF80 -> ready 1 cycle after each request; rdata=0x5A; ext_req never asserted.
//  2. Read 0xC000 with ext_ack 3 cycles after ext_req and ext_rdata=0x3C -> ext_addr=0xC000, ext_we=0; ready the cycle after ack; rdata=0x3C.
//  3. Read 0x8000 with ack never asserted -> ext_req held for 255 cycles, then drops; ready + bus_err pulse together; rdata=0xFF.
//  4. irq_set=5'b00100 and irq_clr=5'b00100 together, starting from IF=0x04; IE=0x04 -> IF bit 2 stays 1; read FF0F=0xE4; irq_pending=1.
//  5. SM83_BOOT_OVERLAY_EN: read 0x0010 -> boot_addr=0x10, boot data returned, no ext_req. Write 0x01 to FF50, read 0x0010 again -> goes external.
//  6. Assert rst_n low during EXT_WAIT -> ext_req=0 immediately; no ready after release; IF=IE=0; FF50 reads 0xFE.

Source files
------------

// File: rtl/sm83_bus_responder.sv
// SM83 data-bus responder: HRAM, IF/IE, boot latch and a req/ack bridge to external memory.
// Define SM83_BOOT_OVERLAY_EN to map the boot ROM over 0x0000 while the boot latch is set.
`timescale 1ns/1ps
module sm83_bus_responder #(
    parameter int unsigned EXT_TIMEOUT = 255,
    parameter int unsigned BOOT_SIZE   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  boot_addr,
    input  logic [7:0]  boot_rdata,
    input  logic [4:0]  irq_set,
    input  logic [4:0]  irq_clr,
    output logic        irq_pending,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, INT_RESP = 2'd1, EXT_WAIT = 2'd2, EXT_RESP = 2'd3} state_t;

    localparam logic [7:0]  TMO_LAST   = 8'(EXT_TIMEOUT - 1);
    localparam logic [16:0] BOOT_LIMIT = 17'(BOOT_SIZE);

    state_t      state_q, state_d;
    logic        boot_wait_q, boot_wait_d;
    logic        boot_sel_q, boot_sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic [7:0]  boot_addr_q, boot_addr_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic        boot_en_q, boot_en_d;
    logic [7:0]  hram_q [0:126];

    logic hram_hit_s, ie_hit_s, if_hit_s, latch_hit_s, unmap_hit_s, internal_s;
    logic boot_win_s, boot_hit_s, accept_s, wr_acc_s, hram_we_s;
    logic [7:0] int_rdata_s;

    // Address decode and internal read mux
    always_comb begin
        hram_hit_s  = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
        ie_hit_s    = (cpu_addr == 16'hFFFF);
        if_hit_s    = (cpu_addr == 16'hFF0F);
        latch_hit_s = (cpu_addr == 16'hFF50);
        unmap_hit_s = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] >= 8'hA0);
        internal_s  = hram_hit_s || ie_hit_s || if_hit_s || latch_hit_s || unmap_hit_s;
        boot_win_s  = ({1'b0, cpu_addr} < BOOT_LIMIT);
`ifdef SM83_BOOT_OVERLAY_EN
        boot_hit_s  = boot_en_q && !cpu_wr && boot_win_s;
`else
        boot_hit_s  = 1'b0;
`endif
        accept_s    = (state_q == IDLE) && (cpu_rd || cpu_wr);
        wr_acc_s    = accept_s && cpu_wr;
        if (cpu_wr) begin
            int_rdata_s = 8'hFF;
        end else if (hram_hit_s) begin
            int_rdata_s = hram_q[cpu_addr[6:0]];
        end else if (ie_hit_s) begin
            int_rdata_s = ie_q;
        end else if (if_hit_s) begin
            int_rdata_s = {3'b111, if_q};
        end else if (latch_hit_s) begin
            int_rdata_s = {7'h7F, ~boot_en_q};
        end else begin
            int_rdata_s = 8'hFF;
        end
    end

    // Internal register updates; a CPU write to IF replaces the held value but set still wins
    always_comb begin
        if (wr_acc_s && if_hit_s) begin
            if_d = cpu_wdata[4:0] | irq_set;
        end else begin
            if_d = (if_q & ~irq_clr) | irq_set;
        end
        if (wr_acc_s && ie_hit_s) begin
            ie_d = cpu_wdata;
        end else begin
            ie_d = ie_q;
        end
        if (wr_acc_s && latch_hit_s && (cpu_wdata != 8'h00)) begin
            boot_en_d = 1'b0;
        end else begin
            boot_en_d = boot_en_q;
        end
        hram_we_s = wr_acc_s && hram_hit_s;
    end

    // HRAM storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (hram_we_s) begin
            hram_q[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            boot_wait_q <= 1'b0;
            boot_sel_q  <= 1'b0;
            cnt_q       <= 8'h00;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 8'hFF;
            bus_err_q   <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 16'h0000;
            ext_wdata_q <= 8'h00;
            boot_addr_q <= 8'h00;
            if_q        <= 5'h00;
            ie_q        <= 8'h00;
            boot_en_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            boot_wait_q <= boot_wait_d;
            boot_sel_q  <= boot_sel_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            boot_addr_q <= boot_addr_d;
            if_q        <= if_d;
            ie_q        <= ie_d;
            boot_en_q   <= boot_en_d;
        end
    end

    // Next-state logic; an ack on the expiry cycle takes priority over the timeout
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_wait_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (boot_hit_s) begin
                        state_d     = INT_RESP;
                        boot_wait_d = 1'b1;
                    end else if (internal_s) begin
                        state_d = INT_RESP;
                    end else begin
                        state_d = EXT_WAIT;
                        cnt_d   = 8'h00;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            INT_RESP: begin
                if (boot_wait_q) begin
                    state_d = INT_RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            EXT_WAIT: begin
                if (ext_ack || (cnt_q == TMO_LAST)) begin
                    state_d = EXT_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EXT_RESP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic feeding the registered outputs
    always_comb begin
        cpu_ready_d = 1'b0;
        cpu_rdata_d = 8'hFF;
        bus_err_d   = 1'b0;
        boot_sel_d  = 1'b0;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        boot_addr_d = boot_addr_q;
        case (state_q)
            IDLE: begin
                if (accept_s && boot_hit_s) begin
                    boot_addr_d = cpu_addr[7:0];
                end else if (accept_s && internal_s) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = int_rdata_s;
                end else if (accept_s) begin
                    ext_req_d   = 1'b1;
                    ext_we_d    = cpu_wr;
                    ext_addr_d  = cpu_addr;
                    ext_wdata_d = cpu_wdata;
                end else begin
                    ext_req_d = 1'b0;
                end
            end
            INT_RESP: begin
                if (boot_wait_q) begin
                    cpu_ready_d = 1'b1;
                    boot_sel_d  = 1'b1;
                end else begin
                    cpu_ready_d = 1'b0;
                end
            end
            EXT_WAIT: begin
                if (ext_ack) begin
                    ext_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = ext_we_q ? 8'hFF : ext_rdata;
                end else if (cnt_q == TMO_LAST) begin
                    ext_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    bus_err_d   = 1'b1;
                end else begin
                    ext_req_d = 1'b1;
                end
            end
            EXT_RESP: ext_req_d = 1'b0;
            default:  ext_req_d = 1'b0;
        endcase
    end

    assign cpu_ready   = cpu_ready_q;
    assign bus_err     = bus_err_q;
    assign ext_req     = ext_req_q;
    assign ext_we      = ext_we_q;
    assign ext_addr    = ext_addr_q;
    assign ext_wdata   = ext_wdata_q;
    assign irq_pending = |(ie_q[4:0] & if_q);
`ifdef SM83_BOOT_OVERLAY_EN
    // Boot ROM data arrives straight from the synchronous ROM in the ready cycle
    assign boot_addr = boot_addr_q;
    assign cpu_rdata = boot_sel_q ? boot_rdata : cpu_rdata_q;
`else
    logic unused_s;
    assign unused_s  = ^{boot_rdata, boot_addr_q, boot_sel_q, boot_win_s};
    assign boot_addr = 8'h00;
    assign cpu_rdata = cpu_rdata_q;
`endif
endmodule

// File: tb/tb_sm83_bus_responder.sv
// Randomized self-checking bench for sm83_bus_responder against a map-level reference model.
`timescale 1ns/1ps
module tb_sm83_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00, cpu_rdata;
    logic        cpu_ready, ext_req, ext_we, ext_ack = 1'b0, irq_pending, bus_err;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata, ext_rdata = 8'h00, boot_addr, boot_rdata = 8'h00;
    logic [4:0]  irq_set = 5'h00, irq_clr = 5'h00;

    int errors = 0, checks = 0;

    // reference model state
    logic [7:0] hram_m [0:126];
    bit         hram_v [0:126];
    logic [7:0] ie_m = 8'h00;
    logic [4:0] if_m = 5'h00;
    bit         boot_en_m = 1'b1;
    logic [7:0] exp_ext [logic [15:0]];
    logic [7:0] dev_mem [logic [15:0]];

    // driver observations
    logic [7:0]  o_rdata, o_wdata;
    logic [15:0] o_addr;
    int          o_lat, o_reqc;
    logic        o_ext, o_berr, o_rnext, o_req_at_rdy, o_we;

    sm83_bus_responder dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata), .boot_addr(boot_addr), .boot_rdata(boot_rdata),
        .irq_set(irq_set), .irq_clr(irq_clr), .irq_pending(irq_pending), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // synchronous boot ROM with a recognisable pattern
    always @(posedge clk) boot_rdata <= boot_addr ^ 8'hA5;

    function automatic logic [7:0] dev_read(input logic [15:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [7:0] ext_val(input logic [15:0] a);
        if (exp_ext.exists(a)) return exp_ext[a];
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic bit is_int(input logic [15:0] a);
        return (a >= 16'hFF80) || (a == 16'hFF0F) || (a == 16'hFF50) ||
               ((a >= 16'hFEA0) && (a <= 16'hFEFF));
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a == 16'hFFFF) return ie_m;
        if (a == 16'hFF0F) return {3'b111, if_m};
        if (a == 16'hFF50) return {7'h7F, ~boot_en_m};
        if (a >= 16'hFF80) return hram_m[int'(a) - 'hFF80];
        return 8'hFF;
    endfunction

    // issue one CPU access and act as the external device; d = ack on d-th ext_req cycle (-1 never)
    task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input int d);
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        o_lat = 0; o_reqc = 0; o_ext = 1'b0; o_berr = 1'b0; o_rdata = 8'h00; o_req_at_rdy = 1'b0;
        for (int c = 1; c <= 400 && o_lat == 0; c++) begin
            ext_ack = 1'b0;
            if (cpu_ready) begin
                o_lat = c; o_rdata = cpu_rdata; o_berr = bus_err; o_req_at_rdy = ext_req;
            end else begin
                if (ext_req) begin
                    o_ext = 1'b1; o_reqc++; o_addr = ext_addr; o_we = ext_we; o_wdata = ext_wdata;
                    if (o_reqc == d) begin
                        ext_ack = 1'b1;
                        if (ext_we) begin
                            dev_mem[ext_addr] = ext_wdata;
                            ext_rdata = 8'($urandom);
                        end else begin
                            ext_rdata = dev_read(ext_addr);
                        end
                    end
                end
                @(posedge clk); #1;
            end
        end
        ext_ack = 1'b0;
        @(posedge clk); #1;
        o_rnext = cpu_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({cpu_ready, cpu_rdata, ext_req, ext_we, ext_addr, ext_wdata, boot_addr, bus_err, irq_pending}
                      !== {1'b0, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_outputs: rdy=%b rdata=%h req=%b we=%b addr=%h wd=%h baddr=%h err=%b irq=%b",
                               cpu_ready, cpu_rdata, ext_req, ext_we, ext_addr, ext_wdata, boot_addr, bus_err, irq_pending);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(16'hFF50, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hFE) begin errors++; $display("FAIL reset_ff50: got %h want fe", o_rdata); end
        access(16'hFF0F, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h want e0", o_rdata); end
    endtask

    task automatic test_hram;
        access(16'hFF80, 1'b0, 1'b1, 8'h5A, 1);
        hram_m[0] = 8'h5A; hram_v[0] = 1'b1;
        checks++; if ({o_lat, o_ext, o_rnext} !== {32'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL hram_wr: lat=%0d ext=%b rnext=%b want 1/0/0", o_lat, o_ext, o_rnext); end
        access(16'hFF80, 1'b1, 1'b0, 8'h00, 1);
        checks++; if ({o_lat, o_ext, o_rdata} !== {32'd1, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL hram_rd: lat=%0d ext=%b rdata=%h want 1/0/5a", o_lat, o_ext, o_rdata); end
        access(16'hFFFE, 1'b0, 1'b1, 8'hA7, 1);
        hram_m[126] = 8'hA7; hram_v[126] = 1'b1;
        access(16'hFFFE, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hA7) begin errors++; $display("FAIL hram_top: got %h want a7", o_rdata); end
        access(16'hFF81, 1'b1, 1'b1, 8'h77, 1);
        hram_m[1] = 8'h77; hram_v[1] = 1'b1;
        checks++; if ({o_lat, o_rdata} !== {32'd1, 8'hFF}) begin
            errors++; $display("FAIL rdwr_both: lat=%0d rdata=%h want 1/ff", o_lat, o_rdata); end
        access(16'hFF81, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'h77) begin errors++; $display("FAIL rdwr_commit: got %h want 77", o_rdata); end
        access(16'hFEA0, 1'b0, 1'b1, 8'h12, 1);
        access(16'hFEFF, 1'b1, 1'b0, 8'h00, 1);
        checks++; if ({o_lat, o_ext, o_rdata} !== {32'd1, 1'b0, 8'hFF}) begin
            errors++; $display("FAIL unmapped: lat=%0d ext=%b rdata=%h want 1/0/ff", o_lat, o_ext, o_rdata); end
    endtask

    task automatic test_ext;
        dev_mem[16'hC000] = 8'h3C; exp_ext[16'hC000] = 8'h3C;
        access(16'hC000, 1'b1, 1'b0, 8'h00, 4);
        checks++; if ({o_addr, o_we, o_reqc, o_lat, o_rdata, o_req_at_rdy, o_rnext}
                      !== {16'hC000, 1'b0, 32'd4, 32'd5, 8'h3C, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ext_read: addr=%h we=%b reqc=%0d lat=%0d rdata=%h req=%b rnext=%b want c000/0/4/5/3c/0/0",
                               o_addr, o_we, o_reqc, o_lat, o_rdata, o_req_at_rdy, o_rnext); end
        access(16'hC001, 1'b0, 1'b1, 8'h9E, 2);
        exp_ext[16'hC001] = 8'h9E;
        checks++; if ({o_we, o_wdata, o_addr, o_lat} !== {1'b1, 8'h9E, 16'hC001, 32'd3}) begin
            errors++; $display("FAIL ext_write: we=%b wd=%h addr=%h lat=%0d want 1/9e/c001/3", o_we, o_wdata, o_addr, o_lat); end
        access(16'hC001, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== ext_val(16'hC001)) begin
            errors++; $display("FAIL ext_readback: got %h want %h", o_rdata, ext_val(16'hC001)); end
    endtask

    task automatic test_timeout;
        access(16'h8000, 1'b1, 1'b0, 8'h00, -1);
        checks++; if ({o_reqc, o_lat, o_berr, o_rdata, o_req_at_rdy, o_rnext}
                      !== {32'd255, 32'd256, 1'b1, 8'hFF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL timeout: reqc=%0d lat=%0d err=%b rdata=%h req=%b rnext=%b want 255/256/1/ff/0/0",
                               o_reqc, o_lat, o_berr, o_rdata, o_req_at_rdy, o_rnext); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_errpulse: got %b want 0", bus_err); end
        access(16'h8001, 1'b1, 1'b0, 8'h00, 255);
        checks++; if ({o_lat, o_berr, o_rdata} !== {32'd256, 1'b0, ext_val(16'h8001)}) begin
            errors++; $display("FAIL ack_at_expiry: lat=%0d err=%b rdata=%h want 256/0/%h",
                               o_lat, o_berr, o_rdata, ext_val(16'h8001)); end
    endtask

    task automatic test_irq;
        access(16'hFFFF, 1'b0, 1'b1, 8'h04, 1); ie_m = 8'h04;
        access(16'hFF0F, 1'b0, 1'b1, 8'h04, 1); if_m = 5'h04;
        irq_set = 5'b00100; irq_clr = 5'b00100;
        @(posedge clk); #1;
        irq_set = 5'h00; irq_clr = 5'h00;
        if_m = (if_m & ~5'b00100) | 5'b00100;
        checks++; if (irq_pending !== |(ie_m[4:0] & if_m)) begin
            errors++; $display("FAIL irq_setclr_pend: got %b want %b", irq_pending, |(ie_m[4:0] & if_m)); end
        access(16'hFF0F, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== {3'b111, if_m}) begin errors++; $display("FAIL irq_setclr_if: got %h want %h", o_rdata, {3'b111, if_m}); end
        irq_clr = 5'b00100;
        @(posedge clk); #1;
        irq_clr = 5'h00; if_m = if_m & ~5'b00100;
        checks++; if (irq_pending !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq_pending); end
        irq_set = 5'b00010;
        access(16'hFF0F, 1'b0, 1'b1, 8'h01, 1);
        irq_set = 5'h00; if_m = 5'h01 | 5'b00010;
        access(16'hFF0F, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== {3'b111, if_m}) begin errors++; $display("FAIL irq_wr_set: got %h want %h", o_rdata, {3'b111, if_m}); end
        access(16'hFFFF, 1'b0, 1'b1, 8'h03, 1); ie_m = 8'h03;
        checks++; if (irq_pending !== |(ie_m[4:0] & if_m)) begin
            errors++; $display("FAIL irq_ie: got %b want %b", irq_pending, |(ie_m[4:0] & if_m)); end
    endtask

    task automatic test_boot;
`ifdef SM83_BOOT_OVERLAY_EN
        access(16'h0010, 1'b1, 1'b0, 8'h00, 2);
        checks++; if ({o_lat, o_ext, o_rdata, boot_addr} !== {32'd2, 1'b0, 8'h10 ^ 8'hA5, 8'h10}) begin
            errors++; $display("FAIL boot_read: lat=%0d ext=%b rdata=%h baddr=%h want 2/0/b5/10", o_lat, o_ext, o_rdata, boot_addr); end
        access(16'h0020, 1'b0, 1'b1, 8'h55, 1); exp_ext[16'h0020] = 8'h55;
        checks++; if (o_ext !== 1'b1) begin errors++; $display("FAIL boot_write_ext: ext=%b want 1", o_ext); end
`else
        access(16'h0010, 1'b1, 1'b0, 8'h00, 2);
        checks++; if ({o_ext, boot_addr} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL noboot_ext: ext=%b baddr=%h want 1/00", o_ext, boot_addr); end
`endif
        access(16'hFF50, 1'b0, 1'b1, 8'h00, 1);
        access(16'hFF50, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hFE) begin errors++; $display("FAIL latch_zero: got %h want fe", o_rdata); end
        access(16'hFF50, 1'b0, 1'b1, 8'h01, 1); boot_en_m = 1'b0;
        access(16'hFF50, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hFF) begin errors++; $display("FAIL latch_set: got %h want ff", o_rdata); end
        access(16'h0010, 1'b1, 1'b0, 8'h00, 2);
        checks++; if ({o_ext, o_lat, o_rdata} !== {1'b1, 32'd3, ext_val(16'h0010)}) begin
            errors++; $display("FAIL after_latch_ext: ext=%b lat=%0d rdata=%h want 1/3/%h", o_ext, o_lat, o_rdata, ext_val(16'h0010)); end
    endtask

    task automatic test_protocol;
        int readies;
        access(16'hFF85, 1'b0, 1'b1, 8'h11, 1); hram_m[5] = 8'h11; hram_v[5] = 1'b1;
        ext_ack = 1'b1;
        @(posedge clk); #1;
        ext_ack = 1'b0;
        checks++; if ({cpu_ready, ext_req} !== 2'b00) begin
            errors++; $display("FAIL stray_ack: rdy=%b req=%b want 0/0", cpu_ready, ext_req); end
        cpu_addr = 16'hC123; cpu_rd = 1'b1;
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_addr = 16'hFF85; cpu_wr = 1'b1; cpu_wdata = 8'h99;
        readies = 0;
        for (int c = 1; c <= 10; c++) begin
            ext_ack = (c == 3);
            ext_rdata = dev_read(16'hC123);
            if (cpu_ready) readies++;
            @(posedge clk); #1;
            cpu_wr = 1'b0;
        end
        ext_ack = 1'b0;
        checks++; if (readies !== 1) begin errors++; $display("FAIL busy_req_readies: got %0d want 1", readies); end
        access(16'hFF85, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'h11) begin errors++; $display("FAIL busy_write_dropped: got %h want 11", o_rdata); end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [7:0]  wd, exp_d;
        logic        rd, wr, boot, intl, known;
        int          d, k, exp_lat;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: a = 16'hFF80 + 16'($urandom_range(0, 126));
                1: a = 16'hFFFF;
                2: a = 16'hFF0F;
                3: a = 16'hFF50;
                4: a = 16'hFEA0 + 16'($urandom_range(0, 95));
                default: a = 16'($urandom_range(0, 16'hFDFF));
            endcase
            k = $urandom_range(0, 2);
            rd = (k != 1); wr = (k != 0);
            wd = 8'($urandom); d = $urandom_range(1, 5);
            intl = is_int(a);
`ifdef SM83_BOOT_OVERLAY_EN
            boot = boot_en_m && !wr && (a < 16'h0100);
`else
            boot = 1'b0;
`endif
            exp_lat = boot ? 2 : (intl ? 1 : d + 1);
            known = 1'b1;
            if (wr) exp_d = 8'hFF;
            else if (boot) exp_d = a[7:0] ^ 8'hA5;
            else if (intl) begin
                exp_d = model_read(a);
                if (a >= 16'hFF80 && a != 16'hFFFF) known = hram_v[int'(a) - 'hFF80];
            end else exp_d = ext_val(a);
            access(a, rd, wr, wd, d);
            checks++; if ({o_lat, o_ext, o_rnext, o_berr} !== {exp_lat, !(intl || boot), 1'b0, 1'b0}) begin
                errors++; $display("FAIL rnd_timing a=%h rd=%b wr=%b: lat=%0d ext=%b rnext=%b err=%b want %0d/%b/0/0",
                                   a, rd, wr, o_lat, o_ext, o_rnext, o_berr, exp_lat, !(intl || boot)); end
            if (rd && !wr && known) begin
                checks++; if (o_rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata a=%h: got %h want %h", a, o_rdata, exp_d); end
            end
            if (!intl && !boot) begin
                checks++; if ({o_addr, o_we} !== {a, wr} || (wr && o_wdata !== wd)) begin
                    errors++; $display("FAIL rnd_ext a=%h: addr=%h we=%b wd=%h want %h/%b/%h", a, o_addr, o_we, o_wdata, a, wr, wd); end
            end
            if (wr) begin
                if (!intl) exp_ext[a] = wd;
                else if (a == 16'hFFFF) ie_m = wd;
                else if (a == 16'hFF0F) if_m = wd[4:0];
                else if (a == 16'hFF50) begin if (wd != 8'h00) boot_en_m = 1'b0; end
                else if (a >= 16'hFF80) begin hram_m[int'(a) - 'hFF80] = wd; hram_v[int'(a) - 'hFF80] = 1'b1; end
            end
            checks++; if (irq_pending !== |(ie_m[4:0] & if_m)) begin
                errors++; $display("FAIL rnd_irq: got %b want %b", irq_pending, |(ie_m[4:0] & if_m)); end
        end
    endtask

    task automatic test_reset_mid;
        int readies;
        access(16'hFFFF, 1'b0, 1'b1, 8'h1F, 1); ie_m = 8'h1F;
        access(16'hFF0F, 1'b0, 1'b1, 8'h1F, 1); if_m = 5'h1F;
        cpu_addr = 16'hC050; cpu_wr = 1'b1; cpu_wdata = 8'h42;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b want 1", ext_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b want 0", ext_req); end
        ie_m = 8'h00; if_m = 5'h00; boot_en_m = 1'b1;
        readies = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) rst_n = 1'b1;
            if (cpu_ready) readies++;
            @(posedge clk); #1;
        end
        checks++; if ({readies, irq_pending} !== {32'd0, 1'b0}) begin
            errors++; $display("FAIL mid_after: readies=%0d irq=%b want 0/0", readies, irq_pending); end
        access(16'hFFFF, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== ie_m) begin errors++; $display("FAIL mid_ie: got %h want %h", o_rdata, ie_m); end
        access(16'hFF0F, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== {3'b111, if_m}) begin errors++; $display("FAIL mid_if: got %h want %h", o_rdata, {3'b111, if_m}); end
        access(16'hFF50, 1'b1, 1'b0, 8'h00, 1);
        checks++; if (o_rdata !== 8'hFE) begin errors++; $display("FAIL mid_ff50: got %h want fe", o_rdata); end
    endtask

    initial begin
        test_reset;
        test_hram;
        test_ext;
        test_timeout;
        test_irq;
        test_boot;
        test_protocol;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
